// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the pipelined RV32I control unit.
//   - ALU, memory-access, data-type, writeback and forwarding encodings
//   - RV32I opcode and funct3 constants
//   - ctrl_bundle_t: the control word carried through ID/EX, EX/MEM, MEM/WB
//   - BUBBLE: the control word of an empty pipeline slot
//   - small decode helpers used by ctrl_decode and ctrl_pipe
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_AND  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_LUI  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_STORE = 2'b01,
        MEM_LOAD  = 2'b10
    } mem_wren_t;

    typedef enum logic [1:0] {
        DT_WORD = 2'b00,
        DT_HALF = 2'b01,
        DT_BYTE = 2'b10,
        DT_NONE = 2'b11
    } data_type_t;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    // Forward select as seen from EX: the value either comes from the
    // register file, the EX/MEM ALU result, or the MEM/WB writeback value.
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic       illegal;       // valid instruction with unknown opcode
        logic       rd_wren;
        logic [4:0] rd_addr;
        alu_op_t    alu_op;
        logic       opa_sel;       // 1: operand A is PC
        logic       opb_sel;       // 1: operand B is the immediate
        logic       br_un;         // unsigned branch compare
        logic       is_branch;
        logic       is_jump;
        logic [2:0] funct3;        // kept for branch resolution in EX
        fwd_sel_t   fwd_a;
        fwd_sel_t   fwd_b;
        mem_wren_t  mem_wren;
        data_type_t data_type;
        logic       mem_unsigned;
        wb_sel_t    wb_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '{
        illegal:      1'b0,
        rd_wren:      1'b0,
        rd_addr:      5'd0,
        alu_op:       ALU_ADD,
        opa_sel:      1'b0,
        opb_sel:      1'b0,
        br_un:        1'b0,
        is_branch:    1'b0,
        is_jump:      1'b0,
        funct3:       3'd0,
        fwd_a:        FWD_RF,
        fwd_b:        FWD_RF,
        mem_wren:     MEM_NONE,
        data_type:    DT_NONE,
        mem_unsigned: 1'b0,
        wb_sel:       WB_MEM
    };

    // ALU operation for R-type and I-ALU instructions. The alternate bit
    // (instr[30]) selects SUB only for register-register ops, since ADDI
    // carries immediate bits there; for shifts it selects SRA in both forms.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       is_reg);
        alu_op_t op;
        case (funct3)
            F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Load/store access size from funct3[1:0].
    function automatic data_type_t size_to_dt(input logic [1:0] size);
        data_type_t dt;
        case (size)
            2'b00:   dt = DT_BYTE;
            2'b01:   dt = DT_HALF;
            2'b10:   dt = DT_WORD;
            default: dt = DT_NONE;
        endcase
        return dt;
    endfunction

    // Branch condition from the stored funct3 and the EX comparator. The
    // comparator itself is told signed/unsigned through br_un, so the
    // unsigned forms reuse the lt result.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = lt;
            F3_BGEU: taken = !lt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I decoder for the ID stage.
//   instr      in  32  IF/ID instruction
//   instr_vld  in  1   instruction is real (0 = bubble)
//   ctrl       out     control bundle for the ID/EX register (fwd fields 00)
//   rs1_addr   out 5   source register 1 field
//   rs2_addr   out 5   source register 2 field
//   rs1_used   out 1   instruction actually reads rs1
//   rs2_used   out 1   instruction actually reads rs2
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic         instr_vld,
    output ctrl_bundle_t ctrl,
    output logic [4:0]   rs1_addr,
    output logic [4:0]   rs2_addr,
    output logic         rs1_used,
    output logic         rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       alt;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign alt      = instr[30];

    // Remaining funct7/immediate bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        ctrl     = BUBBLE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        if (instr_vld) begin
            case (opcode)
                OP_R: begin
                    rs1_used     = 1'b1;
                    rs2_used     = 1'b1;
                    ctrl.rd_wren = 1'b1;
                    ctrl.rd_addr = rd;
                    ctrl.alu_op  = alu_decode(funct3, alt, 1'b1);
                    ctrl.wb_sel  = WB_ALU;
                end
                OP_I: begin
                    rs1_used     = 1'b1;
                    ctrl.rd_wren = 1'b1;
                    ctrl.rd_addr = rd;
                    ctrl.opb_sel = 1'b1;
                    ctrl.alu_op  = alu_decode(funct3, alt, 1'b0);
                    ctrl.wb_sel  = WB_ALU;
                end
                OP_LUI: begin
                    ctrl.rd_wren = 1'b1;
                    ctrl.rd_addr = rd;
                    ctrl.opb_sel = 1'b1;
                    ctrl.alu_op  = ALU_LUI;
                    ctrl.wb_sel  = WB_ALU;
                end
                OP_AUIPC: begin
                    ctrl.rd_wren = 1'b1;
                    ctrl.rd_addr = rd;
                    ctrl.opa_sel = 1'b1;
                    ctrl.opb_sel = 1'b1;
                    ctrl.wb_sel  = WB_ALU;
                end
                OP_LOAD: begin
                    rs1_used          = 1'b1;
                    ctrl.rd_wren      = 1'b1;
                    ctrl.rd_addr      = rd;
                    ctrl.opb_sel      = 1'b1;
                    ctrl.mem_wren     = MEM_LOAD;
                    ctrl.data_type    = size_to_dt(funct3[1:0]);
                    ctrl.mem_unsigned = funct3[2];
                    ctrl.wb_sel       = WB_MEM;
                end
                OP_STORE: begin
                    rs1_used       = 1'b1;
                    rs2_used       = 1'b1;
                    ctrl.opb_sel   = 1'b1;
                    ctrl.mem_wren  = MEM_STORE;
                    ctrl.data_type = size_to_dt(funct3[1:0]);
                end
                OP_BRANCH: begin
                    // ALU computes the target PC+imm; the comparator
                    // works on the forwarded rs1/rs2 values.
                    rs1_used       = 1'b1;
                    rs2_used       = 1'b1;
                    ctrl.opa_sel   = 1'b1;
                    ctrl.opb_sel   = 1'b1;
                    ctrl.is_branch = 1'b1;
                    ctrl.funct3    = funct3;
                    ctrl.br_un     = funct3[1];
                end
                OP_JAL: begin
                    ctrl.rd_wren = 1'b1;
                    ctrl.rd_addr = rd;
                    ctrl.opa_sel = 1'b1;
                    ctrl.opb_sel = 1'b1;
                    ctrl.is_jump = 1'b1;
                    ctrl.wb_sel  = WB_PC4;
                end
                OP_JALR: begin
                    rs1_used     = 1'b1;
                    ctrl.rd_wren = 1'b1;
                    ctrl.rd_addr = rd;
                    ctrl.opb_sel = 1'b1;
                    ctrl.is_jump = 1'b1;
                    ctrl.wb_sel  = WB_PC4;
                end
                default: begin
                    // Unknown opcode: inert slot that still reports itself
                    // at writeback.
                    ctrl.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control unit of the 5-stage RV32I core.
// Decodes the ID instruction, carries the control bundle through ID/EX,
// EX/MEM and MEM/WB, detects load-use / RAW hazards, computes forwarding
// selects and resolves branch/jump redirects in EX.
// Parameters:
//   FWD_EN    1: forward from EX/MEM and MEM/WB, stall only on load-use
//             0: no forwarding, stall on any RAW hazard against EX or MEM
//   ALU_OP_W  width of o_ex_alu_op (codes zero-extended)
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_instr, i_instr_vld      IF/ID instruction and its valid flag
//   i_br_eq, i_br_lt          EX branch comparator results
//   o_stall, o_flush          hold PC and IF/ID / kill IF/ID
//   o_ex_*                    EX stage controls (ALU op, operand muxes,
//                             unsigned compare, forward selects, PC select)
//   o_mem_*                   MEM stage access type, size, zero-extend
//   o_wb_*                    WB write enable, rd, writeback mux, illegal
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [31:0]         i_instr,
    input  logic                i_instr_vld,
    input  logic                i_br_eq,
    input  logic                i_br_lt,
    output logic                o_stall,
    output logic                o_flush,
    output logic [ALU_OP_W-1:0] o_ex_alu_op,
    output logic                o_ex_opa_sel,
    output logic                o_ex_opb_sel,
    output logic                o_ex_br_un,
    output logic [1:0]          o_ex_fwd_a,
    output logic [1:0]          o_ex_fwd_b,
    output logic                o_ex_pc_sel,
    output logic [1:0]          o_mem_wren,
    output logic [1:0]          o_mem_data_type,
    output logic                o_mem_unsigned,
    output logic                o_wb_rd_wren,
    output logic [4:0]          o_wb_rd_addr,
    output logic [1:0]          o_wb_sel,
    output logic                o_wb_illegal
);

    ctrl_bundle_t idex_reg;
    ctrl_bundle_t exmem_reg;
    ctrl_bundle_t memwb_reg;
    ctrl_bundle_t idex_next;
    ctrl_bundle_t dec_ctrl;

    // Index 0 is rs1, index 1 is rs2.
    logic [1:0][4:0] rs_addr;
    logic [1:0]      rs_used;
    logic [1:0]      match_ex;
    logic [1:0]      match_mem;
    fwd_sel_t        fwd_sel [2];

    logic ex_producer;
    logic mem_producer;
    logic load_use;
    logic raw_hazard;
    logic stall_raw;
    logic ex_pc_sel;

    ctrl_decode u_decode (
        .instr     (i_instr),
        .instr_vld (i_instr_vld),
        .ctrl      (dec_ctrl),
        .rs1_addr  (rs_addr[0]),
        .rs2_addr  (rs_addr[1]),
        .rs1_used  (rs_used[0]),
        .rs2_used  (rs_used[1])
    );

    // A stage only produces a value if it writes a register other than x0.
    assign ex_producer  = idex_reg.rd_wren  && (idex_reg.rd_addr  != 5'd0);
    assign mem_producer = exmem_reg.rd_wren && (exmem_reg.rd_addr != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign match_ex[gi]  = rs_used[gi] && ex_producer
                                   && (idex_reg.rd_addr == rs_addr[gi]);
            assign match_mem[gi] = rs_used[gi] && mem_producer
                                   && (exmem_reg.rd_addr == rs_addr[gi]);
            // Selects are named for where the producer will sit once this
            // instruction reaches EX: today's ID/EX becomes EX/MEM and
            // today's EX/MEM becomes MEM/WB. The younger producer wins.
            assign fwd_sel[gi] = !FWD_EN      ? FWD_RF    :
                                 match_ex[gi]  ? FWD_EXMEM :
                                 match_mem[gi] ? FWD_MEMWB : FWD_RF;
        end
    endgenerate

    assign load_use   = (idex_reg.mem_wren == MEM_LOAD) && (|match_ex);
    assign raw_hazard = (|match_ex) || (|match_mem);
    assign stall_raw  = FWD_EN ? load_use : raw_hazard;

    // Redirect resolved from the instruction currently in EX.
    assign ex_pc_sel = idex_reg.is_jump
                       || (idex_reg.is_branch
                           && branch_taken(idex_reg.funct3, i_br_eq, i_br_lt));

    assign o_flush = ex_pc_sel;
    // A jump in EX redirects unconditionally, so its flush masks any stall.
    // A taken branch is not used to mask the stall: that would put the
    // comparator on the stall path. Both cases still load a bubble into
    // ID/EX, and the PC redirect takes precedence over the hold.
    assign o_stall = stall_raw && !idex_reg.is_jump;

    always_comb begin
        idex_next       = dec_ctrl;
        idex_next.fwd_a = fwd_sel[0];
        idex_next.fwd_b = fwd_sel[1];
        if (ex_pc_sel || stall_raw) begin
            idex_next = BUBBLE;
        end
    end

    // EX/MEM and MEM/WB advance unconditionally; only the ID/EX input is
    // subject to stall and flush.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idex_reg  <= BUBBLE;
            exmem_reg <= BUBBLE;
            memwb_reg <= BUBBLE;
        end else begin
            idex_reg  <= idex_next;
            exmem_reg <= idex_reg;
            memwb_reg <= exmem_reg;
        end
    end

    assign o_ex_alu_op     = ALU_OP_W'(idex_reg.alu_op);
    assign o_ex_opa_sel    = idex_reg.opa_sel;
    assign o_ex_opb_sel    = idex_reg.opb_sel;
    assign o_ex_br_un      = idex_reg.br_un;
    assign o_ex_fwd_a      = idex_reg.fwd_a;
    assign o_ex_fwd_b      = idex_reg.fwd_b;
    assign o_ex_pc_sel     = ex_pc_sel;

    assign o_mem_wren      = exmem_reg.mem_wren;
    assign o_mem_data_type = exmem_reg.data_type;
    assign o_mem_unsigned  = exmem_reg.mem_unsigned;

    assign o_wb_rd_wren    = memwb_reg.rd_wren;
    assign o_wb_rd_addr    = memwb_reg.rd_addr;
    assign o_wb_sel        = memwb_reg.wb_sel;
    assign o_wb_illegal    = memwb_reg.illegal;

    // MEM/WB carries the full bundle for uniformity; only the WB fields
    // leave the block.
    logic unused_memwb_bits;
    assign unused_memwb_bits = ^memwb_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    localparam logic [31:0] INS_ADD   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] INS_SUB   = 32'h40118233; // sub x4,x3,x1
    localparam logic [31:0] INS_LW    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] INS_ADD55 = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] INS_JAL   = 32'h008000EF; // jal x1,+8
    localparam logic [31:0] INS_BLTU  = 32'h0020E463; // bltu x1,x2,+8
    localparam logic [31:0] INS_BAD   = 32'h0000007F; // unknown opcode

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        vld;
    logic        br_eq;
    logic        br_lt;

    always #5 clk = ~clk;

    // DUT with forwarding
    logic       d1_stall, d1_flush, d1_opa, d1_opb, d1_br_un, d1_pc_sel;
    logic [3:0] d1_alu_op;
    logic [1:0] d1_fwd_a, d1_fwd_b, d1_mem_wren, d1_mem_dt, d1_wb_sel;
    logic       d1_mem_uns, d1_wb_wren, d1_wb_ill;
    logic [4:0] d1_wb_rd;

    // DUT without forwarding
    logic       d0_stall, d0_flush, d0_opa, d0_opb, d0_br_un, d0_pc_sel;
    logic [3:0] d0_alu_op;
    logic [1:0] d0_fwd_a, d0_fwd_b, d0_mem_wren, d0_mem_dt, d0_wb_sel;
    logic       d0_mem_uns, d0_wb_wren, d0_wb_ill;
    logic [4:0] d0_wb_rd;

    ctrl_pipe #(.FWD_EN(1'b1), .ALU_OP_W(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_vld(vld),
        .i_br_eq(br_eq), .i_br_lt(br_lt),
        .o_stall(d1_stall), .o_flush(d1_flush),
        .o_ex_alu_op(d1_alu_op), .o_ex_opa_sel(d1_opa), .o_ex_opb_sel(d1_opb),
        .o_ex_br_un(d1_br_un), .o_ex_fwd_a(d1_fwd_a), .o_ex_fwd_b(d1_fwd_b),
        .o_ex_pc_sel(d1_pc_sel), .o_mem_wren(d1_mem_wren),
        .o_mem_data_type(d1_mem_dt), .o_mem_unsigned(d1_mem_uns),
        .o_wb_rd_wren(d1_wb_wren), .o_wb_rd_addr(d1_wb_rd),
        .o_wb_sel(d1_wb_sel), .o_wb_illegal(d1_wb_ill)
    );

    ctrl_pipe #(.FWD_EN(1'b0), .ALU_OP_W(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_vld(vld),
        .i_br_eq(br_eq), .i_br_lt(br_lt),
        .o_stall(d0_stall), .o_flush(d0_flush),
        .o_ex_alu_op(d0_alu_op), .o_ex_opa_sel(d0_opa), .o_ex_opb_sel(d0_opb),
        .o_ex_br_un(d0_br_un), .o_ex_fwd_a(d0_fwd_a), .o_ex_fwd_b(d0_fwd_b),
        .o_ex_pc_sel(d0_pc_sel), .o_mem_wren(d0_mem_wren),
        .o_mem_data_type(d0_mem_dt), .o_mem_unsigned(d0_mem_uns),
        .o_wb_rd_wren(d0_wb_wren), .o_wb_rd_addr(d0_wb_rd),
        .o_wb_sel(d0_wb_sel), .o_wb_illegal(d0_wb_ill)
    );

    // EX tuple: {alu_op, fwd_a, fwd_b, opa, opb, br_un, pc_sel}
    // WB tuple: {rd_wren, rd_addr, wb_sel, illegal}
    logic [11:0] ex1, ex0;
    logic [8:0]  wb1, wb0;
    assign ex1 = {d1_alu_op, d1_fwd_a, d1_fwd_b, d1_opa, d1_opb, d1_br_un, d1_pc_sel};
    assign ex0 = {d0_alu_op, d0_fwd_a, d0_fwd_b, d0_opa, d0_opb, d0_br_un, d0_pc_sel};
    assign wb1 = {d1_wb_wren, d1_wb_rd, d1_wb_sel, d1_wb_ill};
    assign wb0 = {d0_wb_wren, d0_wb_rd, d0_wb_sel, d0_wb_ill};

    // Scoreboard: expected stage tuples pushed when an instruction is driven,
    // popped when it reaches that stage.
    logic [11:0] ex_q [$];
    logic [8:0]  wb_q [$];

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = INS_ADD; vld = 1'b1; br_eq = 1'b0; br_lt = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({d1_stall, d1_flush, ex1, d1_mem_wren, d1_mem_uns, wb1} !== 26'd0) begin
            failures++;
            $display("FAIL reset_zero_fwd: got %h want 0",
                     {d1_stall, d1_flush, ex1, d1_mem_wren, d1_mem_uns, wb1});
        end
        checks++;
        if (d1_mem_dt !== 2'b11) begin
            failures++;
            $display("FAIL reset_dt_fwd: got %b want 11", d1_mem_dt);
        end
        checks++;
        if ({d0_stall, d0_flush, ex0, d0_mem_wren, d0_mem_uns, wb0} !== 26'd0) begin
            failures++;
            $display("FAIL reset_zero_nofwd: got %h want 0",
                     {d0_stall, d0_flush, ex0, d0_mem_wren, d0_mem_uns, wb0});
        end
        checks++;
        if (d0_mem_dt !== 2'b11) begin
            failures++;
            $display("FAIL reset_dt_nofwd: got %b want 11", d0_mem_dt);
        end
        tick();
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_add_sub_fwd();
        logic [11:0] e_ex;
        logic [8:0]  e_wb;
        idle(3);
        ex_q.push_back({4'b0000, 2'b00, 2'b00, 4'b0000});
        ex_q.push_back({4'b0001, 2'b01, 2'b00, 4'b0000});
        wb_q.push_back({1'b1, 5'd3, 2'b01, 1'b0});
        wb_q.push_back({1'b1, 5'd4, 2'b01, 1'b0});
        instr = INS_ADD; vld = 1'b1;
        @(negedge clk);
        checks++;
        if (d1_stall !== 1'b0) begin
            failures++; $display("FAIL addsub_stall_c0: got %b want 0", d1_stall);
        end
        tick();
        instr = INS_SUB;
        @(negedge clk);
        checks++;
        if (d1_stall !== 1'b0) begin
            failures++; $display("FAIL addsub_stall_c1: got %b want 0", d1_stall);
        end
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL addsub_ex_add: got %b want %b", ex1, e_ex);
        end
        tick();
        vld = 1'b0;
        @(negedge clk);
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL addsub_ex_sub: got %b want %b", ex1, e_ex);
        end
        tick();
        @(negedge clk);
        e_wb = wb_q.pop_front();
        checks++;
        if (wb1 !== e_wb) begin
            failures++; $display("FAIL addsub_wb_add: got %b want %b", wb1, e_wb);
        end
        tick();
        @(negedge clk);
        e_wb = wb_q.pop_front();
        checks++;
        if (wb1 !== e_wb) begin
            failures++; $display("FAIL addsub_wb_sub: got %b want %b", wb1, e_wb);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [11:0] e_ex;
        logic [8:0]  e_wb;
        idle(3);
        ex_q.push_back({4'b0000, 2'b00, 2'b00, 4'b0100}); // lw: opb=imm
        ex_q.push_back(12'd0);                            // stall bubble
        ex_q.push_back({4'b0000, 2'b10, 2'b10, 4'b0000}); // add x6,x5,x5
        wb_q.push_back({1'b1, 5'd5, 2'b00, 1'b0});
        instr = INS_LW; vld = 1'b1;
        tick();
        instr = INS_ADD55;
        @(negedge clk);
        checks++;
        if (d1_stall !== 1'b1) begin
            failures++; $display("FAIL lu_stall_on: got %b want 1", d1_stall);
        end
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL lu_ex_lw: got %b want %b", ex1, e_ex);
        end
        tick();
        @(negedge clk);
        checks++;
        if (d1_stall !== 1'b0) begin
            failures++; $display("FAIL lu_stall_off: got %b want 0", d1_stall);
        end
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL lu_ex_bubble: got %b want %b", ex1, e_ex);
        end
        checks++;
        if ({d1_mem_wren, d1_mem_dt, d1_mem_uns} !== 5'b10_00_0) begin
            failures++;
            $display("FAIL lu_mem_lw: got %b want 10000", {d1_mem_wren, d1_mem_dt, d1_mem_uns});
        end
        tick();
        vld = 1'b0;
        @(negedge clk);
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL lu_ex_add: got %b want %b", ex1, e_ex);
        end
        e_wb = wb_q.pop_front();
        checks++;
        if (wb1 !== e_wb) begin
            failures++; $display("FAIL lu_wb_lw: got %b want %b", wb1, e_wb);
        end
        tick();
    endtask

    task automatic test_raw_nofwd();
        logic [11:0] e_ex;
        idle(3);
        ex_q.push_back({4'b0001, 2'b00, 2'b00, 4'b0000});
        instr = INS_ADD; vld = 1'b1;
        tick();
        instr = INS_SUB;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (d0_stall !== (c < 2)) begin
                failures++;
                $display("FAIL nofwd_stall_c%0d: got %b want %b", c, d0_stall, (c < 2));
            end
            tick();
        end
        vld = 1'b0;
        @(negedge clk);
        e_ex = ex_q.pop_front();
        checks++;
        if (ex0 !== e_ex) begin
            failures++; $display("FAIL nofwd_ex_sub: got %b want %b", ex0, e_ex);
        end
        tick();
    endtask

    task automatic test_jal();
        logic [11:0] e_ex;
        logic [8:0]  e_wb;
        idle(3);
        ex_q.push_back({4'b0000, 2'b00, 2'b00, 4'b1101});
        ex_q.push_back(12'd0);
        wb_q.push_back({1'b1, 5'd1, 2'b10, 1'b0});
        wb_q.push_back(9'd0);
        instr = INS_JAL; vld = 1'b1;
        tick();
        instr = INS_ADD;
        @(negedge clk);
        checks++;
        if ({d1_flush, d1_stall} !== 2'b10) begin
            failures++; $display("FAIL jal_flush: got %b want 10", {d1_flush, d1_stall});
        end
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL jal_ex: got %b want %b", ex1, e_ex);
        end
        tick();
        vld = 1'b0;
        @(negedge clk);
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL jal_ex_bubble: got %b want %b", ex1, e_ex);
        end
        checks++;
        if (d1_flush !== 1'b0) begin
            failures++; $display("FAIL jal_flush_off: got %b want 0", d1_flush);
        end
        tick();
        @(negedge clk);
        e_wb = wb_q.pop_front();
        checks++;
        if (wb1 !== e_wb) begin
            failures++; $display("FAIL jal_wb: got %b want %b", wb1, e_wb);
        end
        tick();
        @(negedge clk);
        e_wb = wb_q.pop_front();
        checks++;
        if (wb1 !== e_wb) begin
            failures++; $display("FAIL jal_wb_killed: got %b want %b", wb1, e_wb);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [11:0] e_ex;
        idle(3);
        ex_q.push_back({4'b0000, 2'b00, 2'b00, 4'b1111});
        instr = INS_BLTU; vld = 1'b1;
        tick();
        vld = 1'b0; br_lt = 1'b1; br_eq = 1'b0;
        @(negedge clk);
        e_ex = ex_q.pop_front();
        checks++;
        if (ex1 !== e_ex) begin
            failures++; $display("FAIL bltu_taken_ex: got %b want %b", ex1, e_ex);
        end
        checks++;
        if (d1_flush !== 1'b1) begin
            failures++; $display("FAIL bltu_taken_flush: got %b want 1", d1_flush);
        end
        br_lt = 1'b0;
        #1;
        checks++;
        if ({d1_pc_sel, d1_flush} !== 2'b00) begin
            failures++; $display("FAIL bltu_not_taken: got %b want 00", {d1_pc_sel, d1_flush});
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [8:0] e_wb;
        idle(3);
        wb_q.push_back({1'b0, 5'd0, 2'b00, 1'b1});
        instr = INS_BAD; vld = 1'b1;
        tick();
        vld = 1'b0;
        @(negedge clk);
        checks++;
        if (ex1 !== 12'd0) begin
            failures++; $display("FAIL illegal_ex: got %b want 0", ex1);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({d1_mem_wren, d1_mem_dt} !== 4'b0011) begin
            failures++; $display("FAIL illegal_mem: got %b want 0011", {d1_mem_wren, d1_mem_dt});
        end
        tick();
        @(negedge clk);
        e_wb = wb_q.pop_front();
        checks++;
        if (wb1 !== e_wb) begin
            failures++; $display("FAIL illegal_wb: got %b want %b", wb1, e_wb);
        end
        tick();
    endtask

    task automatic test_bubble_no_hazard();
        idle(3);
        instr = INS_LW; vld = 1'b1;
        tick();
        instr = INS_ADD55; vld = 1'b0;
        @(negedge clk);
        checks++;
        if ({d1_stall, d0_stall} !== 2'b00) begin
            failures++; $display("FAIL bubble_no_stall: got %b want 00", {d1_stall, d0_stall});
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        instr = INS_LW; vld = 1'b1;
        tick();
        instr = INS_ADD55;
        @(negedge clk);
        checks++;
        if (d1_stall !== 1'b1) begin
            failures++; $display("FAIL rms_stall_pre: got %b want 1", d1_stall);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({d1_stall, d1_flush, ex1, d1_mem_wren, wb1} !== 25'd0) begin
            failures++;
            $display("FAIL rms_zero: got %h want 0", {d1_stall, d1_flush, ex1, d1_mem_wren, wb1});
        end
        checks++;
        if (d1_mem_dt !== 2'b11) begin
            failures++; $display("FAIL rms_dt: got %b want 11", d1_mem_dt);
        end
        tick();
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_sub_fwd();
        test_load_use();
        test_raw_nofwd();
        test_jal();
        test_branch();
        test_illegal();
        test_bubble_no_hazard();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
